// File: rtl/adc_fmt_pkg.sv
// adc_fmt_pkg: shared definitions for the ADC sample formatter.
//   fmt_mode_e  - output format select encodings (mode port)
//   cal_state_e - DC-offset calibration FSM states
package adc_fmt_pkg;

    typedef enum logic [1:0] {
        MODE_OFFSET = 2'b00,  // offset-binary to two's complement (MSB flip)
        MODE_RAW    = 2'b01,  // bit-for-bit passthrough
        MODE_CAL    = 2'b10,  // subtract calibrated DC offset, saturate
        MODE_RSVD   = 2'b11   // behaves as MODE_OFFSET
    } fmt_mode_e;

    typedef enum logic [1:0] {
        CAL_IDLE  = 2'b00,
        CAL_ACCUM = 2'b01,
        CAL_ROUND = 2'b10,
        CAL_LOAD  = 2'b11
    } cal_state_e;

endpackage

// File: rtl/adc_dc_cal.sv
// adc_dc_cal: DC-offset calibration engine.
//   Averages 2^CAL_LOG2 valid input samples (rounded to nearest) after a
//   cal_start request and loads the result into dc_offset.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid, in_data - raw unsigned ADC samples
//   cal_start         - calibration request, ignored while busy
//   dc_offset         - current offset register (midscale after reset)
//   cal_busy          - high in ACCUM, ROUND, LOAD
//   cal_done          - one-cycle pulse in the cycle the offset is loaded
module adc_dc_cal
    import adc_fmt_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CAL_LOG2 = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              cal_start,
    output logic [DATA_W-1:0] dc_offset,
    output logic              cal_busy,
    output logic              cal_done
);

    localparam int unsigned ACC_W = DATA_W + CAL_LOG2;

    localparam logic [CAL_LOG2:0] CNT_LAST = (CAL_LOG2 + 1)'((1 << CAL_LOG2) - 1);
    localparam logic [ACC_W:0]    RND_HALF = (ACC_W + 1)'(1) << (CAL_LOG2 - 1);
    localparam logic [ACC_W:0]    AVG_MAX  = {{(CAL_LOG2 + 1){1'b0}}, {DATA_W{1'b1}}};

    cal_state_e        state, state_nxt;
    logic [ACC_W-1:0]  acc;
    logic [CAL_LOG2:0] cnt;
    logic [DATA_W-1:0] avg_q;

    logic              acc_clr;
    logic              acc_en;
    logic              round_en;
    logic              load_en;
    logic              last_sample;

    logic [ACC_W:0]    rounded;
    logic [ACC_W:0]    shifted;
    logic [DATA_W-1:0] avg_c;

    assign last_sample = in_valid && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CAL_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cal_busy  = 1'b0;
        cal_done  = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        round_en  = 1'b0;
        load_en   = 1'b0;
        case (state)
            CAL_IDLE: begin
                if (cal_start) begin
                    acc_clr   = 1'b1;
                    state_nxt = CAL_ACCUM;
                end
            end
            CAL_ACCUM: begin
                cal_busy = 1'b1;
                acc_en   = in_valid;
                if (last_sample) begin
                    state_nxt = CAL_ROUND;
                end
            end
            CAL_ROUND: begin
                cal_busy  = 1'b1;
                round_en  = 1'b1;
                state_nxt = CAL_LOAD;
            end
            CAL_LOAD: begin
                cal_busy  = 1'b1;
                cal_done  = 1'b1;
                load_en   = 1'b1;
                state_nxt = CAL_IDLE;
            end
            default: state_nxt = CAL_IDLE;
        endcase
    end

    // Round to nearest by adding half an LSB of the shifted result; the
    // extra top bit keeps the carry so the saturation test sees it.
    always_comb begin
        rounded = {1'b0, acc} + RND_HALF;
        shifted = rounded >> CAL_LOG2;
        avg_c   = (shifted > AVG_MAX) ? '1 : shifted[DATA_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            avg_q     <= '0;
            dc_offset <= {1'b1, {(DATA_W - 1){1'b0}}};
        end else begin
            if (acc_clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (acc_en) begin
                acc <= acc + {{CAL_LOG2{1'b0}}, in_data};
                cnt <= cnt + 1'b1;
            end
            if (round_en) begin
                avg_q <= avg_c;
            end
            if (load_en) begin
                dc_offset <= avg_q;
            end
        end
    end

endmodule

// File: rtl/adc_sample_format.sv
// adc_sample_format: two-stage ADC sample formatter with DC calibration.
//   Stage 1 registers the raw sample, valid and mode; stage 2 registers the
//   formatted two's-complement result. Latency is two cycles.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   in_valid, in_data - unsigned ADC samples
//   mode              - 00/11 offset-binary, 01 raw, 10 offset-subtract
//   cal_start         - start DC-offset calibration
//   out_valid         - qualifies out_data/out_sat
//   out_data, out_sat - formatted sample and clamp flag (held when invalid)
//   cal_busy,cal_done - calibration status
//   dc_offset         - current offset register
module adc_sample_format
    import adc_fmt_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CAL_LOG2 = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        mode,
    input  logic              cal_start,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat,
    output logic              cal_busy,
    output logic              cal_done,
    output logic [DATA_W-1:0] dc_offset
);

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    fmt_mode_e         s1_mode;

    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] fmt_data;
    logic              fmt_sat;

    adc_dc_cal #(
        .DATA_W   (DATA_W),
        .CAL_LOG2 (CAL_LOG2)
    ) u_dc_cal (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .cal_start (cal_start),
        .dc_offset (dc_offset),
        .cal_busy  (cal_busy),
        .cal_done  (cal_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= MODE_OFFSET;
        end else begin
            s1_valid <= in_valid;
            s1_data  <= in_data;
            s1_mode  <= fmt_mode_e'(mode);
        end
    end

    // Signed overflow of the DATA_W+1-bit difference shows up as the top
    // two bits disagreeing; the top bit then gives the clamp direction.
    always_comb begin
        diff     = {1'b0, s1_data} - {1'b0, dc_offset};
        fmt_data = {~s1_data[DATA_W-1], s1_data[DATA_W-2:0]};
        fmt_sat  = 1'b0;
        case (s1_mode)
            MODE_RAW: begin
                fmt_data = s1_data;
            end
            MODE_CAL: begin
                if (diff[DATA_W] != diff[DATA_W-1]) begin
                    fmt_sat  = 1'b1;
                    fmt_data = diff[DATA_W] ? {1'b1, {(DATA_W - 1){1'b0}}}
                                            : {1'b0, {(DATA_W - 1){1'b1}}};
                end else begin
                    fmt_data = diff[DATA_W-1:0];
                end
            end
            default: begin
                fmt_data = {~s1_data[DATA_W-1], s1_data[DATA_W-2:0]};
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= fmt_data;
                out_sat  <= fmt_sat;
            end
        end
    end

endmodule

// File: doc/adc_sample_format.md
ADC_SAMPLE_FORMAT -- requirements
Module: adc_sample_format

Interface
REQ-001 SHALL have parameter DATA_W, default 8, sample width in bits (>=4).
REQ-002 SHALL have parameter CAL_LOG2, default 8, log2 of calibration sample count (1..16).
REQ-003 SHALL have port clk, input, 1, sole clock, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, qualifies in_data.
REQ-006 SHALL have port in_data, input, DATA_W, unsigned ADC sample.
REQ-007 SHALL have port mode, input, 2, format select: 00 offset-binary, 01 raw passthrough, 10 calibrated subtract, 11 reserved (treated as 00).
REQ-008 SHALL have port cal_start, input, 1, single-cycle calibration request.
REQ-009 SHALL have port out_valid, output, 1, qualifies out_data.
REQ-010 SHALL have port out_data, output, DATA_W, signed two's-complement sample.
REQ-011 SHALL have port out_sat, output, 1, out_data was clamped this sample.
REQ-012 SHALL have port cal_busy, output, 1, calibration in progress.
REQ-013 SHALL have port cal_done, output, 1, one-cycle pulse when new offset is loaded.
REQ-014 SHALL have port dc_offset, output, DATA_W, current unsigned offset register.

Function
REQ-015 Data path SHALL be a 2-stage pipeline: stage 1 registers in_data, in_valid, mode; stage 2 registers out_data, out_valid, out_sat; latency exactly 2 cycles, one sample per cycle, no backpressure.
REQ-016 out_valid SHALL equal in_valid delayed 2 cycles; out_data/out_sat SHALL hold their last value while out_valid=0.
REQ-017 Mode 00/11: out_data = in_data with MSB inverted; out_sat=0 (0x00->0x80, 0x80->0x00, 0xFF->0x7F at DATA_W=8).
REQ-018 Mode 01: out_data = in_data bit-for-bit; out_sat=0.
REQ-019 Mode 10: diff = in_data - dc_offset computed at DATA_W+1 bits signed; clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; out_sat=1 iff clamped.
REQ-020 Mode SHALL be sampled per sample at stage 1; a mode change affects only samples entering after it.
REQ-021 Calibration FSM states: IDLE, ACCUM, ROUND, LOAD; IDLE->ACCUM on cal_start; ACCUM->ROUND after 2^CAL_LOG2 valid samples; ROUND->LOAD next cycle; LOAD->IDLE next cycle.
REQ-022 ACCUM SHALL sum unsigned in_data on in_valid cycles only into a DATA_W+CAL_LOG2-bit accumulator cleared on entry; a sample counter counts to 2^CAL_LOG2.
REQ-023 ROUND SHALL compute avg = (acc + 2^(CAL_LOG2-1)) >> CAL_LOG2, saturated to 2^DATA_W-1.
REQ-024 LOAD SHALL write avg to dc_offset and pulse cal_done for exactly that cycle.
REQ-025 cal_busy SHALL be 1 in ACCUM, ROUND, LOAD; 0 in IDLE.
REQ-026 cal_start while cal_busy=1 SHALL be ignored.
REQ-027 Data path SHALL keep running during calibration using the old dc_offset; the new offset applies to stage-2 results from the cycle after LOAD.
REQ-028 in_valid=0 during ACCUM SHALL stall the count; calibration has no timeout.

Reset
REQ-029 While rst=1: out_valid=0, out_data=0, out_sat=0, cal_busy=0, cal_done=0, pipeline valids=0, FSM=IDLE, accumulator and counter=0.
REQ-030 dc_offset SHALL reset to 2^(DATA_W-1) (midscale), so mode 10 after reset equals mode 00 for in-range data.
REQ-031 Reset during calibration SHALL abort it with no dc_offset update and no cal_done.

Structure
REQ-032 Package adc_fmt_pkg SHALL hold mode encodings and the calibration state enum.
REQ-033 Calibration FSM, accumulator and counter SHALL be sub-module adc_dc_cal, exporting dc_offset, cal_busy, cal_done.

Verification
REQ-034 Reset release, mode 00, in 0x00,0x80,0xFF consecutive -> out 0x80,0x00,0x7F two cycles later, out_sat=0, dc_offset=0x80.
REQ-035 Mode 10, CAL_LOG2=2, cal_start then 4 samples 0x90 -> cal_done one pulse, dc_offset=0x90; next input 0x90 -> out 0x00.
REQ-036 Mode 10, dc_offset=0xFF, in 0x00 -> out 0x80, out_sat=1; dc_offset=0x00, in 0xFF -> out 0x7F, out_sat=1.
REQ-037 in_valid gaps during ACCUM plus cal_start pulses while busy -> count stalls, single calibration, averaging 4 valid samples 0x10,0x11,0x11,0x11 -> dc_offset=0x11 (rounded).
REQ-038 Assert rst mid-ACCUM -> cal_busy=0, dc_offset=0x80, no cal_done; subsequent cal_start completes normally.
